// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - decode operand fetch with EX/MEM/WB forwarding, load-use stall and ID/EX register
module id_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [AW-1:0]   id_dest,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  output logic [AW-1:0]   gpr_raddr1,
  output logic [AW-1:0]   gpr_raddr2,
  input  logic [DW-1:0]   gpr_rdata1,
  input  logic [DW-1:0]   gpr_rdata2,
  input  logic [DW-1:0]   ex_fwd_data,
  input  logic            mem_reg_write,
  input  logic [AW-1:0]   mem_dest,
  input  logic [DW-1:0]   mem_fwd_data,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_dest,
  input  logic [DW-1:0]   wb_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            stall,
  output logic            idex_valid,
  output logic [DW-1:0]   idex_op1,
  output logic [DW-1:0]   idex_op2,
  output logic [AW-1:0]   idex_dest,
  output logic            idex_reg_write,
  output logic            idex_is_load,
  output logic [CNTW-1:0] stall_count
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   op1_q, op1_d;
  logic [DW-1:0]   op2_q, op2_d;
  logic [AW-1:0]   dest_q, dest_d;
  logic            reg_write_q, reg_write_d;
  logic            is_load_q, is_load_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            load_use;
  logic            ex_can_fwd;

  assign gpr_raddr1 = id_rs;
  assign gpr_raddr2 = id_rt;

  // A load in EX has no data yet, so it must not forward; it stalls instead.
  assign ex_can_fwd = valid_q & reg_write_q & ~is_load_q;

  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] src,
                                            input logic [DW-1:0] gpr_val);
    logic [DW-1:0] val;
    if (src == '0)                                val = '0;
    else if (ex_can_fwd && dest_q == src)         val = ex_fwd_data;
    else if (mem_reg_write && mem_dest == src)    val = mem_fwd_data;
    else if (wb_we && wb_dest == src)             val = wb_data;
    else                                          val = gpr_val;
    return val;
  endfunction

  always_comb begin
    load_use = id_valid & valid_q & is_load_q & reg_write_q & (dest_q != '0) &
               ((id_use_rs & (id_rs == dest_q)) | (id_use_rt & (id_rt == dest_q)));
  end

  assign stall = load_use | ex_hold;

  always_comb begin
    valid_d     = valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    if (flush) begin
      valid_d     = 1'b0;
      op1_d       = '0;
      op2_d       = '0;
      dest_d      = '0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
    end else if (ex_hold) begin
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
    end else begin
      valid_d     = id_valid;
      op1_d       = resolve(id_rs, gpr_rdata1);
      op2_d       = resolve(id_rt, gpr_rdata2);
      dest_d      = id_dest;
      reg_write_d = id_reg_write & id_valid;
      is_load_d   = id_is_load & id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
    end
  end

  assign idex_valid     = valid_q;
  assign idex_op1       = op1_q;
  assign idex_op2       = op2_q;
  assign idex_dest      = dest_q;
  assign idex_reg_write = reg_write_q;
  assign idex_is_load   = is_load_q;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed self-checking bench for id_operand_stage
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CNTW = 4;

  logic clk, reset;
  logic id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
  logic [AW-1:0] id_rs, id_rt, id_dest, gpr_raddr1, gpr_raddr2, mem_dest, wb_dest, idex_dest;
  logic [DW-1:0] gpr_rdata1, gpr_rdata2, ex_fwd_data, mem_fwd_data, wb_data, idex_op1, idex_op2;
  logic mem_reg_write, wb_we, ex_hold, flush, stall;
  logic idex_valid, idex_reg_write, idex_is_load;
  logic [CNTW-1:0] stall_count;

  int total = 0;
  int bad = 0;

  id_operand_stage #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
    .gpr_rdata1(gpr_rdata1), .gpr_rdata2(gpr_rdata2),
    .ex_fwd_data(ex_fwd_data),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_hold(ex_hold), .flush(flush), .stall(stall),
    .idex_valid(idex_valid), .idex_op1(idex_op1), .idex_op2(idex_op2),
    .idex_dest(idex_dest), .idex_reg_write(idex_reg_write), .idex_is_load(idex_is_load),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] dest, input logic load);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = 1'b1; id_use_rt = 1'b1;
    id_dest = dest; id_reg_write = 1'b1; id_is_load = load;
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dest = 0; id_reg_write = 0; id_is_load = 0;
    gpr_rdata1 = 0; gpr_rdata2 = 0; ex_fwd_data = 0;
    mem_reg_write = 0; mem_dest = 0; mem_fwd_data = 0;
    wb_we = 0; wb_dest = 0; wb_data = 0; ex_hold = 0; flush = 0;
    step(); step();
    check("rst_valid", idex_valid, 0);
    check("rst_op1", idex_op1, 0);
    check("rst_cnt", stall_count, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;

    // plain register read
    instr(5'd3, 5'd0, 5'd9, 1'b0);
    gpr_rdata1 = 32'h11;
    #1 check("raddr1", gpr_raddr1, 3);
    step();
    check("plain_op1", idex_op1, 32'h11);
    check("plain_valid", idex_valid, 1);
    check("plain_dest", idex_dest, 9);
    check("plain_rw", idex_reg_write, 1);

    // EX beats MEM
    instr(5'd1, 5'd0, 5'd5, 1'b0);
    gpr_rdata1 = 0;
    step();
    instr(5'd5, 5'd0, 5'd6, 1'b0);
    ex_fwd_data = 32'hAA; mem_reg_write = 1; mem_dest = 5; mem_fwd_data = 32'hBB; gpr_rdata1 = 32'hCC;
    #1 check("ex_fwd_nostall", stall, 0);
    step();
    check("ex_prio", idex_op1, 32'hAA);

    // EX invalid, MEM supplies
    id_valid = 0;
    step();
    check("bubble_valid", idex_valid, 0);
    instr(5'd5, 5'd0, 5'd6, 1'b0);
    step();
    check("mem_fwd", idex_op1, 32'hBB);

    // WB bypass of a stale gpr read
    mem_reg_write = 0;
    instr(5'd0, 5'd7, 5'd11, 1'b0);
    wb_we = 1; wb_dest = 7; wb_data = 32'h1234; gpr_rdata2 = 0;
    step();
    check("wb_fwd", idex_op2, 32'h1234);
    wb_we = 0;

    // load-use on r8
    instr(5'd0, 5'd0, 5'd8, 1'b1);
    step();
    check("ld_is_load", idex_is_load, 1);
    instr(5'd0, 5'd8, 5'd10, 1'b0);
    #1 check("lu_stall", stall, 1);
    step();
    check("lu_bubble_valid", idex_valid, 0);
    check("lu_bubble_ld", idex_is_load, 0);
    check("lu_bubble_rw", idex_reg_write, 0);
    check("lu_cnt", stall_count, 1);
    check("lu_released", stall, 0);
    mem_reg_write = 1; mem_dest = 8; mem_fwd_data = 32'h55;
    step();
    check("lu_mem_op2", idex_op2, 32'h55);
    check("lu_valid", idex_valid, 1);

    // r0 never stalls nor forwards
    mem_reg_write = 0;
    instr(5'd0, 5'd0, 5'd0, 1'b1);
    step();
    instr(5'd0, 5'd0, 5'd12, 1'b0);
    gpr_rdata2 = 32'h77; mem_reg_write = 1; mem_dest = 0; mem_fwd_data = 32'hFF; ex_fwd_data = 32'hEE;
    #1 check("r0_nostall", stall, 0);
    step();
    check("r0_op2", idex_op2, 0);
    check("r0_valid", idex_valid, 1);

    // flush during load-use
    mem_reg_write = 0;
    instr(5'd0, 5'd0, 5'd8, 1'b1);
    step();
    instr(5'd0, 5'd8, 5'd13, 1'b0);
    flush = 1;
    #1 check("fl_stall", stall, 1);
    step();
    flush = 0;
    check("fl_valid", idex_valid, 0);
    check("fl_op2", idex_op2, 0);
    check("fl_cnt", stall_count, 2);

    // saturation under a long ex_hold, ID/EX held
    reset = 1; #1; reset = 0;
    check("rst2_cnt", stall_count, 0);
    instr(5'd3, 5'd0, 5'd9, 1'b0);
    gpr_rdata1 = 32'h11;
    step();
    check("hold_pre", idex_op1, 32'h11);
    ex_hold = 1; gpr_rdata1 = 32'h22;
    for (int i = 0; i < 15; i++) step();
    check("sat_15", stall_count, 15);
    for (int i = 0; i < 5; i++) step();
    check("sat_hold", stall_count, 15);
    check("hold_op1", idex_op1, 32'h11);
    check("hold_valid", idex_valid, 1);

    // reset in the middle of a stall
    ex_hold = 0;
    instr(5'd0, 5'd0, 5'd8, 1'b1);
    step();
    instr(5'd0, 5'd8, 5'd13, 1'b0);
    #1 check("mid_stall", stall, 1);
    reset = 1; #1;
    check("mid_rst_valid", idex_valid, 0);
    check("mid_rst_cnt", stall_count, 0);
    check("mid_rst_stall", stall, 0);
    reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
